// File: rtl/booth_mult_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier: FSM states and
// the recode of one multiplier bit pair into an add/subtract/no-op action.
package booth_mult_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_e;

   typedef enum logic [1:0] {
      NOP,
      ADD,
      SUB
   } booth_op_e;

   // Input is {b[i], b[i-1]}.
   function automatic booth_op_e booth_recode(input logic [1:0] pair);
      case (pair)
         2'b01:   return ADD;
         2'b10:   return SUB;
         default: return NOP;
      endcase
   endfunction

endpackage

// File: rtl/booth_mult_seq_step.sv
// One combinational radix-2 Booth stage: recode, add/subtract the multiplicand
// into the upper half, then arithmetic-shift {hi, q, q_m1} right by one bit.
module booth_step
   import booth_mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH+1:0] i_hi,
   input  logic [WIDTH:0]   i_q,
   input  logic             i_q_m1,
   input  logic [WIDTH:0]   i_m,
   output logic [WIDTH+1:0] o_hi,
   output logic [WIDTH:0]   o_q,
   output logic             o_q_m1
);

   logic [WIDTH+1:0] w_m_ext;
   logic [WIDTH+1:0] w_sum;
   booth_op_e        w_op;

   // The upper half carries one guard bit, so subtracting the most negative
   // multiplicand cannot wrap before the shift.
   assign w_m_ext = {i_m[WIDTH], i_m};
   assign w_op    = booth_recode({i_q[0], i_q_m1});

   always_comb begin
      w_sum = i_hi;
      case (w_op)
         ADD:     w_sum = i_hi + w_m_ext;
         SUB:     w_sum = i_hi - w_m_ext;
         default: w_sum = i_hi;
      endcase
   end

   assign o_hi   = {w_sum[WIDTH+1], w_sum[WIDTH+1:1]};
   assign o_q    = {w_sum[0], i_q[WIDTH:1]};
   assign o_q_m1 = i_q[0];

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned, one step per cycle
// over WIDTH+1 steps, with valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// CALC  | one Booth step per cycle, down-counter tracks steps left
// DONE  | product held on out_product until out_ready
module booth_mult_seq
   import booth_mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_product,
   output logic                 busy
);

   localparam int CW = $clog2(WIDTH + 1);

   state_e             r_state;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH+1:0]   r_hi;
   logic [WIDTH:0]     r_q;
   logic               r_q_m1;
   logic [WIDTH:0]     r_m;
   logic [2*WIDTH-1:0] r_product;
   logic               r_in_ready;
   logic               r_out_valid;
   logic               r_busy;

   logic [WIDTH+1:0]   w_hi;
   logic [WIDTH:0]     w_q;
   logic               w_q_m1;

   booth_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_hi   (r_hi),
      .i_q    (r_q),
      .i_q_m1 (r_q_m1),
      .i_m    (r_m),
      .o_hi   (w_hi),
      .o_q    (w_q),
      .o_q_m1 (w_q_m1)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_hi        <= '0;
         r_q         <= '0;
         r_q_m1      <= 1'b0;
         r_m         <= '0;
         r_product   <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_m        <= {in_signed & in_a[WIDTH-1], in_a};
                  r_q        <= {in_signed & in_b[WIDTH-1], in_b};
                  r_hi       <= '0;
                  r_q_m1     <= 1'b0;
                  r_cnt      <= CW'(WIDTH);
                  r_state    <= CALC;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            CALC: begin
               r_hi   <= w_hi;
               r_q    <= w_q;
               r_q_m1 <= w_q_m1;
               if (r_cnt == '0) begin
                  // {hi, q} now holds the product; keep its low 2*WIDTH bits.
                  r_product   <= {w_hi[WIDTH-2:0], w_q};
                  r_state     <= DONE;
                  r_out_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign busy        = r_busy;
   assign out_product = r_product;

endmodule

// File: doc/booth_mult_seq.md
BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an operand pair is offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-006 The block SHALL have ports in_a and in_b, input, WIDTH bits each: multiplicand and multiplier.
REQ-007 The block SHALL have port in_signed, input, 1 bit: 1 treats operands as two's complement, 0 as unsigned.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_product holds a result.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port out_product, output, 2*WIDTH bits: the full-width product.
REQ-011 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 The block SHALL implement a state machine with states IDLE, CALC and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 An input transfer SHALL occur on an edge where in_valid and in_ready are both 1; the block then captures in_a, in_b and in_signed and enters CALC.
REQ-015 In CALC the block SHALL perform one radix-2 Booth step per cycle: inspect multiplier bit pair {b[i], b[i-1]}, add on 01, subtract on 10, no-op on 00/11, then arithmetic-shift right.
REQ-016 Operands SHALL be extended to WIDTH+1 bits, sign-extended if in_signed=1 and zero-extended otherwise; CALC SHALL take exactly WIDTH+1 steps, tracked by a step counter.
REQ-017 The internal accumulator SHALL be at least 2*WIDTH+2 bits wide so that no intermediate result overflows.
REQ-018 out_product SHALL equal the low 2*WIDTH bits of the exact product of the extended operands, for all operand values in both modes.
REQ-019 out_valid SHALL rise exactly WIDTH+1 cycles after the input-transfer edge.
REQ-020 In DONE, out_product SHALL stay stable until out_ready=1; on that edge the block SHALL return to IDLE.
REQ-021 Minimum initiation interval SHALL be WIDTH+3 cycles; the block SHALL not overlap operations.
REQ-022 in_valid in CALC or DONE SHALL be ignored, and changes to the input operands after capture SHALL have no effect.
REQ-023 out_ready while not in DONE SHALL have no effect.
REQ-024 out_product SHALL be held at its last value in IDLE and CALC.

Reset
REQ-025 While rst_n=0 at a clock edge, the block SHALL go to IDLE and clear the accumulator, step counter and out_product to 0.
REQ-026 After reset the outputs SHALL be in_ready=1, out_valid=0, busy=0, out_product=0.
REQ-027 A reset in CALC or DONE SHALL discard the operation in flight with no result produced, and a new transfer SHALL be accepted on the first edge after rst_n returns to 1.

Structure
REQ-028 Package booth_mult_pkg SHALL hold the state enum typedef and the Booth recode constants (NOP, ADD, SUB).
REQ-029 One sub-module, booth_step, SHALL implement a single recode/add-subtract/arithmetic-shift stage as combinational logic; the top module SHALL hold the FSM, step counter and registers.

Verification (WIDTH=8 unless stated)
REQ-030 Unsigned 255 x 255 -> out_product=0xFE01, with out_valid rising exactly 9 cycles after the accept edge.
REQ-031 Signed mode: 0x80 x 0x80 -> 0x4000; 0xFF x 0x01 -> 0xFFFF; 0x7F x 0x80 -> 0xC080.
REQ-032 Operands 0x80 x 0x02 -> 0x0100 unsigned and 0xFF00 signed.
REQ-033 out_ready held 0 for 5 cycles in DONE -> out_product stable, in_ready=0, and a concurrent in_valid is not accepted.
REQ-034 rst_n=0 for one cycle at CALC step 4 -> next cycle in_ready=1, out_valid=0, out_product=0, and no stale result appears afterwards.
REQ-035 10k random pairs in both modes at WIDTH=4, 8 and 16, with random in_valid/out_ready stalls -> every result matches the reference model and no transfer is lost or duplicated.
